// File: rtl/fix_stream_arbiter.sv
// rtl/fix_stream_arbiter.sv - round-robin arbiter merging session byte streams into one FIX parser
module fix_stream_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MAX_MSG_LEN = 1024,
    localparam int SW         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int LW         = $clog2(MAX_MSG_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               last_o,
    output logic [SW-1:0]      sel_o,
    output logic               busy_o,
    output logic               abort_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [7:0] SOH = 8'h01;

    state_t          state, state_n;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   last_grant;
    logic [LW-1:0]   len_cnt;
    logic            abort_q;

    logic [SW-1:0]   winner;
    logic            any_req;
    logic            do_grant;
    logic            len_inc;
    logic            enter_drain;

    logic [7:0]      data_arr [N_REQ];
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;

    // Unpack the flat data bus so the granted byte can be picked by index
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            data_arr[k] = req_data_i[8*k +: 8];
        end
    end

    assign sel_valid = req_valid_i[sel];
    assign sel_last  = req_last_i[sel];
    assign sel_data  = data_arr[sel];
    assign any_req   = |req_valid_i;

    // Round-robin search starting one past the previous grant, wrapping around
    always_comb begin
        logic [SW-1:0] idx;
        logic          found;
        winner = last_grant;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = SW'((int'(last_grant) + i) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next-state and output decode; outputs stay inactive unless a state drives them
    always_comb begin
        state_n     = state;
        valid_o     = 1'b0;
        data_o      = 8'h00;
        last_o      = 1'b0;
        req_ready_o = '0;
        do_grant    = 1'b0;
        len_inc     = 1'b0;
        enter_drain = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    do_grant = 1'b1;
                    state_n  = SYNC;
                end
            end
            SYNC: begin
                valid_o = 1'b1;
                data_o  = SOH;
                if (ready_i) begin
                    state_n = STREAM;
                end
            end
            STREAM: begin
                valid_o          = sel_valid;
                data_o           = sel_data;
                last_o           = sel_last;
                req_ready_o[sel] = ready_i;
                if (sel_valid && ready_i) begin
                    len_inc = 1'b1;
                    if (sel_last) begin
                        state_n = IDLE;
                    end else if (len_cnt == LW'(MAX_MSG_LEN - 1)) begin
                        enter_drain = 1'b1;
                        state_n     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                req_ready_o[sel] = 1'b1;
                if (sel_valid && sel_last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_o  = (state != IDLE);
    assign sel_o   = sel;
    assign abort_o = abort_q;

    // State, grant bookkeeping, saturating length counter and abort pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= SW'(N_REQ - 1);
            len_cnt    <= '0;
            abort_q    <= 1'b0;
        end else begin
            state   <= state_n;
            abort_q <= enter_drain;
            if (do_grant) begin
                sel        <= winner;
                last_grant <= winner;
                len_cnt    <= '0;
            end else if (len_inc && (len_cnt != LW'(MAX_MSG_LEN))) begin
                len_cnt <= len_cnt + LW'(1);
            end
        end
    end

endmodule
